// File: rtl/barrier_pkg.sv
// Shared types and constants for the barrier spawn scheduler and its slots.
package barrier_pkg;

   localparam int unsigned COORD_W  = 10;
   localparam int unsigned SCREEN_W = 640;

   // One barrier slot: valid flag plus on-screen geometry.
   typedef struct packed {
      logic               valid;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] height;
      logic [COORD_W-1:0] length;
   } barrier_t;

   localparam int unsigned BARRIER_W = $bits(barrier_t);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_CAPTURE
   } spawn_state_e;

   // Coordinate add that clamps at the largest representable value.
   function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
      logic [COORD_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[COORD_W] ? {COORD_W{1'b1}} : sum[COORD_W-1:0];
   endfunction

endpackage

// File: rtl/barrier_slot.sv
// One barrier slot register with clear, capture-write and scroll/free logic.
module barrier_slot
   import barrier_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 clear,
   input  logic                 scroll_en,
   input  logic [3:0]           scroll_speed,
   input  logic                 wr_en,
   input  logic [BARRIER_W-1:0] wr_data,
   output logic                 valid,
   output logic [BARRIER_W-1:0] slot_nxt_c
);

   barrier_t slot_r;
   barrier_t slot_d;

   // Next slot value: clear beats capture, capture beats scroll.
   always_comb begin
      slot_d = slot_r;
      if (clear) begin
         slot_d = '0;
      end else if (wr_en) begin
         slot_d = barrier_t'(wr_data);
      end else if (scroll_en && slot_r.valid) begin
         if (slot_r.x >= COORD_W'(scroll_speed)) begin
            slot_d.x = slot_r.x - COORD_W'(scroll_speed);
         end else begin
            slot_d = '0;
         end
      end
   end

   // Slot storage.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         slot_r <= '0;
      end else begin
         slot_r <= slot_d;
      end
   end

   assign valid      = slot_r.valid;
   assign slot_nxt_c = slot_d;

endmodule

// File: rtl/barrier_spawn_scheduler.sv
// Barrier slot pool: paces spawns from the parameter generator and scrolls slots.
module barrier_spawn_scheduler
   import barrier_pkg::*;
#(
   parameter int unsigned NUM_SLOTS      = 4,
   parameter int unsigned SPAWN_INTERVAL = 90,
   parameter int unsigned GEN_LATENCY    = 2,
   parameter int unsigned SPAWN_X_OFFSET = 140
)(
   input  logic                         Clk,
   input  logic                         Reset_N,
   input  logic                         Enable,
   input  logic                         Clear,
   input  logic                         Frame_Tick,
   input  logic [3:0]                   Scroll_Speed,
   output logic                         Gen_Load,
   input  logic [9:0]                   Gen_X,
   input  logic [9:0]                   Gen_Y,
   input  logic [9:0]                   Gen_Height,
   input  logic [9:0]                   Gen_Length,
   input  logic [$clog2(NUM_SLOTS)-1:0] Rd_Slot,
   output logic                         Rd_Valid,
   output logic [9:0]                   Rd_X,
   output logic [9:0]                   Rd_Y,
   output logic [9:0]                   Rd_Height,
   output logic [9:0]                   Rd_Length,
   output logic [3:0]                   Active_Count,
   output logic                         Spawn_Pending
);

   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned LAT_W  = 3;
   localparam int unsigned ACT_W  = 4;

   spawn_state_e         state_q;
   spawn_state_e         state_d;
   logic [CNT_W-1:0]     frame_cnt_q;
   logic                 spawn_due_q;
   logic [LAT_W-1:0]     wait_cnt_q;
   logic                 gen_load_q;
   logic                 spawn_pending_q;
   barrier_t             rd_q;
   logic [ACT_W-1:0]     active_count_q;
   logic [ACT_W-1:0]     count_nxt;
   logic [NUM_SLOTS-1:0] valid_q;
   logic [NUM_SLOTS-1:0] valid_nxt;
   logic [BARRIER_W-1:0] slot_nxt [NUM_SLOTS];
   logic [SLOT_W-1:0]    free_idx;
   logic                 any_free;
   logic                 tick_en;
   logic                 interval_hit;
   logic                 capture_c;
   logic                 gen_load_nxt;
   barrier_t             cap_data;

   assign tick_en      = Frame_Tick && Enable;
   assign interval_hit = tick_en && (frame_cnt_q == CNT_W'(SPAWN_INTERVAL - 1));

   // Lowest-index free slot; it stays free until this scheduler writes it.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx = SLOT_W'(i);
            any_free = 1'b1;
         end
      end
   end

   // Captured parameters, X shifted to the right-hand spawn position.
   always_comb begin
      cap_data        = '0;
      cap_data.valid  = 1'b1;
      cap_data.x      = sat_add(Gen_X, COORD_W'(SPAWN_X_OFFSET));
      cap_data.y      = Gen_Y;
      cap_data.height = Gen_Height;
      cap_data.length = Gen_Length;
   end

   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
      barrier_slot u_slot (
         .Clk          (Clk),
         .Reset_N      (Reset_N),
         .clear        (Clear),
         .scroll_en    (tick_en),
         .scroll_speed (Scroll_Speed),
         .wr_en        (capture_c && (free_idx == SLOT_W'(g))),
         .wr_data      (cap_data),
         .valid        (valid_q[g]),
         .slot_nxt_c   (slot_nxt[g])
      );
      assign valid_nxt[g] = slot_nxt[g][BARRIER_W-1];
   end

   // Spawn FSM state register.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Spawn FSM next state; once launched a spawn runs to capture regardless of Enable.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (spawn_due_q && any_free && Enable) state_d = ST_LOAD;
         ST_LOAD:    state_d = ST_WAIT;
         ST_WAIT:    if (wait_cnt_q == LAT_W'(GEN_LATENCY - 1)) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      if (Clear) state_d = ST_IDLE;
   end

   // Spawn FSM outputs.
   always_comb begin
      capture_c    = 1'b0;
      gen_load_nxt = 1'b0;
      if (state_q == ST_CAPTURE && !Clear) capture_c = 1'b1;
      if (state_d == ST_LOAD) gen_load_nxt = 1'b1;
   end

   // Active slot count after this edge's updates.
   always_comb begin
      count_nxt = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         count_nxt = count_nxt + ACT_W'(valid_nxt[i]);
      end
   end

   // Frame pacing, generator latency counter and registered outputs.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         frame_cnt_q     <= '0;
         spawn_due_q     <= 1'b0;
         wait_cnt_q      <= '0;
         gen_load_q      <= 1'b0;
         spawn_pending_q <= 1'b0;
         rd_q            <= '0;
         active_count_q  <= '0;
      end else if (Clear) begin
         frame_cnt_q     <= '0;
         spawn_due_q     <= 1'b0;
         wait_cnt_q      <= '0;
         gen_load_q      <= 1'b0;
         spawn_pending_q <= 1'b0;
         rd_q            <= '0;
         active_count_q  <= '0;
      end else begin
         if (tick_en) begin
            frame_cnt_q <= interval_hit ? '0 : frame_cnt_q + CNT_W'(1);
         end
         if (capture_c) begin
            spawn_due_q <= 1'b0;
         end else if (interval_hit) begin
            spawn_due_q <= 1'b1;
         end
         wait_cnt_q      <= (state_q == ST_WAIT) ? wait_cnt_q + LAT_W'(1) : '0;
         gen_load_q      <= gen_load_nxt;
         spawn_pending_q <= spawn_due_q && !any_free;
         rd_q            <= barrier_t'(slot_nxt[Rd_Slot]);
         active_count_q  <= count_nxt;
      end
   end

   assign Gen_Load      = gen_load_q;
   assign Rd_Valid      = rd_q.valid;
   assign Rd_X          = rd_q.x;
   assign Rd_Y          = rd_q.y;
   assign Rd_Height     = rd_q.height;
   assign Rd_Length     = rd_q.length;
   assign Active_Count  = active_count_q;
   assign Spawn_Pending = spawn_pending_q;

endmodule

// File: tb/tb_barrier_spawn_scheduler.sv
// Self-checking bench for barrier_spawn_scheduler: reference model plus directed scenarios.
module tb_barrier_spawn_scheduler;

   localparam int NS  = 4;
   localparam int SI  = 90;
   localparam int GL  = 2;
   localparam int OFF = 140;

   logic       Clk = 1'b0;
   logic       Reset_N = 1'b0;
   logic       Enable = 1'b1;
   logic       Clear = 1'b0;
   logic       Frame_Tick = 1'b0;
   logic [3:0] Scroll_Speed = '0;
   logic [9:0] Gen_X = '0, Gen_Y = '0, Gen_Height = '0, Gen_Length = '0;
   logic [1:0] Rd_Slot = '0;
   logic       Gen_Load, Rd_Valid, Spawn_Pending;
   logic [9:0] Rd_X, Rd_Y, Rd_Height, Rd_Length;
   logic [3:0] Active_Count;

   int errors = 0;
   int checks = 0;
   int n_loads = 0;

   // Reference model: slot contents, frame pacing, and age of the spawn in flight.
   int m_v[NS], m_x[NS], m_y[NS], m_h[NS], m_l[NS];
   int m_cnt, m_due, m_busy, m_age, m_pend, m_load;
   int m_rv, m_rx, m_ry, m_rh, m_rl, m_count;

   barrier_spawn_scheduler #(
      .NUM_SLOTS(NS), .SPAWN_INTERVAL(SI), .GEN_LATENCY(GL), .SPAWN_X_OFFSET(OFF)
   ) dut (
      .Clk(Clk), .Reset_N(Reset_N), .Enable(Enable), .Clear(Clear),
      .Frame_Tick(Frame_Tick), .Scroll_Speed(Scroll_Speed), .Gen_Load(Gen_Load),
      .Gen_X(Gen_X), .Gen_Y(Gen_Y), .Gen_Height(Gen_Height), .Gen_Length(Gen_Length),
      .Rd_Slot(Rd_Slot), .Rd_Valid(Rd_Valid), .Rd_X(Rd_X), .Rd_Y(Rd_Y),
      .Rd_Height(Rd_Height), .Rd_Length(Rd_Length), .Active_Count(Active_Count),
      .Spawn_Pending(Spawn_Pending)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NS; i++) begin
         m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_h[i] = 0; m_l[i] = 0;
      end
      m_cnt = 0; m_due = 0; m_busy = 0; m_age = 0; m_pend = 0; m_load = 0;
      m_rv = 0; m_rx = 0; m_ry = 0; m_rh = 0; m_rl = 0; m_count = 0;
   endfunction

   // Advance the model by one clock edge using the inputs held across that edge.
   function automatic void model_step();
      int tgt, cap, start, pend_new, expire, sp, sx;
      if (Clear) begin
         model_reset();
         return;
      end
      tgt = -1;
      for (int i = NS - 1; i >= 0; i--) if (m_v[i] == 0) tgt = i;
      cap      = (m_busy != 0 && m_age == GL + 1) ? 1 : 0;
      start    = (m_busy == 0 && m_due != 0 && tgt >= 0 && Enable) ? 1 : 0;
      pend_new = (m_due != 0 && tgt < 0) ? 1 : 0;
      expire   = 0;
      sp       = int'(Scroll_Speed);
      if (Frame_Tick && Enable) begin
         if (m_cnt == SI - 1) begin
            m_cnt = 0;
            expire = 1;
         end else begin
            m_cnt++;
         end
         for (int i = 0; i < NS; i++) begin
            if (m_v[i] != 0) begin
               if (m_x[i] >= sp) m_x[i] -= sp;
               else begin
                  m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_h[i] = 0; m_l[i] = 0;
               end
            end
         end
      end
      if (cap != 0 && tgt >= 0) begin
         sx = int'(Gen_X) + OFF;
         m_v[tgt] = 1;
         m_x[tgt] = (sx > 1023) ? 1023 : sx;
         m_y[tgt] = int'(Gen_Y);
         m_h[tgt] = int'(Gen_Height);
         m_l[tgt] = int'(Gen_Length);
      end
      if (cap != 0) m_due = 0;
      else if (expire != 0) m_due = 1;
      if (cap != 0) m_busy = 0;
      else if (m_busy != 0) m_age++;
      if (start != 0) begin
         m_busy = 1;
         m_age  = 0;
      end
      m_pend  = pend_new;
      m_load  = (m_busy != 0 && m_age == 0) ? 1 : 0;
      m_rv    = m_v[Rd_Slot]; m_rx = m_x[Rd_Slot]; m_ry = m_y[Rd_Slot];
      m_rh    = m_h[Rd_Slot]; m_rl = m_l[Rd_Slot];
      m_count = 0;
      for (int i = 0; i < NS; i++) m_count += m_v[i];
   endfunction

   // One clock: update the model at the edge, compare just after, drop single-cycle pulses.
   task automatic cyc();
      @(posedge Clk);
      model_step();
      #1;
      chk("gen_load", int'(Gen_Load), m_load);
      chk("rd_valid", int'(Rd_Valid), m_rv);
      chk("rd_x", int'(Rd_X), m_rx);
      chk("rd_y", int'(Rd_Y), m_ry);
      chk("rd_height", int'(Rd_Height), m_rh);
      chk("rd_length", int'(Rd_Length), m_rl);
      chk("active_count", int'(Active_Count), m_count);
      chk("spawn_pending", int'(Spawn_Pending), m_pend);
      if (Gen_Load) n_loads++;
      Frame_Tick = 1'b0;
      Clear      = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         Frame_Tick = 1'b1;
         cyc();
         cyc();
      end
   endtask

   task automatic wait_load();
      int i;
      i = 0;
      while (!Gen_Load && i < 20) begin
         cyc();
         i++;
      end
      chk("wait_gen_load", int'(Gen_Load), 1);
   endtask

   task automatic spawn(input int gx, input int gy, input int gh, input int gln);
      Gen_X = 10'(gx); Gen_Y = 10'(gy); Gen_Height = 10'(gh); Gen_Length = 10'(gln);
      tick(SI);
      wait_load();
      repeat (6) cyc();
   endtask

   initial begin
      int n0, found;
      model_reset();

      // Reset values.
      #23;
      chk("reset_gen_load", int'(Gen_Load), 0);
      chk("reset_rd_valid", int'(Rd_Valid), 0);
      chk("reset_rd_x", int'(Rd_X), 0);
      chk("reset_active", int'(Active_Count), 0);
      chk("reset_pending", int'(Spawn_Pending), 0);
      Reset_N = 1'b1;
      cyc();

      // Basic spawn into slot0 and its latency.
      Gen_X = 10'd200; Gen_Y = 10'd45; Gen_Height = 10'd20; Gen_Length = 10'd30;
      n_loads = 0;
      tick(SI);
      wait_load();
      repeat (3) cyc();
      chk("s1_not_yet_valid", int'(Rd_Valid), 0);
      cyc();
      chk("s1_valid", int'(Rd_Valid), 1);
      chk("s1_x", int'(Rd_X), 340);
      chk("s1_y", int'(Rd_Y), 45);
      chk("s1_h", int'(Rd_Height), 20);
      chk("s1_l", int'(Rd_Length), 30);
      chk("s1_active", int'(Active_Count), 1);
      repeat (4) cyc();
      chk("s1_one_load", n_loads, 1);

      // Scroll down to underflow, with Enable dropped while the spawn is in flight.
      Clear = 1'b1; cyc();
      Gen_X = 10'd0; Gen_Y = 10'd1; Gen_Height = 10'd2; Gen_Length = 10'd3;
      tick(SI);
      wait_load();
      Enable = 1'b0;
      repeat (6) cyc();
      Enable = 1'b1;
      chk("s2_start_x", int'(Rd_X), 140);
      Scroll_Speed = 4'd10;
      tick(13);
      chk("s2_x10", int'(Rd_X), 10);
      Scroll_Speed = 4'd4;
      tick(1);
      chk("s2_x6", int'(Rd_X), 6);
      tick(1);
      chk("s2_x2", int'(Rd_X), 2);
      tick(1);
      chk("s2_gone", int'(Rd_Valid), 0);
      Scroll_Speed = 4'd0;

      // Full pool, pending spawn, refill with a saturated X.
      Clear = 1'b1; cyc();
      spawn(500, 11, 12, 13);
      spawn(500, 21, 22, 23);
      spawn(0, 31, 32, 33);
      spawn(500, 41, 42, 43);
      chk("s3_full", int'(Active_Count), 4);
      n0 = n_loads;
      tick(SI);
      repeat (3) cyc();
      chk("s3_pending", int'(Spawn_Pending), 1);
      chk("s3_no_load", n_loads - n0, 0);
      Gen_X = 10'd1000;
      Scroll_Speed = 4'd15;
      Rd_Slot = 2'd2;
      cyc();
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         Frame_Tick = 1'b1;
         cyc();
         if (!Rd_Valid) found = 1;
      end
      chk("s3_slot2_freed", found, 1);
      Scroll_Speed = 4'd0;
      cyc();
      chk("s3_load_next_cycle", int'(Gen_Load), 1);
      repeat (6) cyc();
      chk("s3_refill_valid", int'(Rd_Valid), 1);
      chk("s3_refill_sat_x", int'(Rd_X), 1023);
      chk("s3_refill_y", int'(Rd_Y), 41);
      chk("s3_refill_active", int'(Active_Count), 4);

      // Clear during WAIT aborts the capture and restarts the interval.
      Clear = 1'b1; cyc();
      Rd_Slot = 2'd0;
      Gen_X = 10'd10; Gen_Y = 10'd5; Gen_Height = 10'd6; Gen_Length = 10'd7;
      tick(SI);
      wait_load();
      cyc();
      Clear = 1'b1;
      cyc();
      repeat (8) cyc();
      for (int s = 0; s < NS; s++) begin
         Rd_Slot = 2'(s);
         cyc();
         chk("s5_slot_cleared", int'(Rd_Valid), 0);
      end
      Rd_Slot = 2'd0;
      n0 = n_loads;
      tick(SI - 1);
      repeat (5) cyc();
      chk("s5_no_early_load", n_loads - n0, 0);
      Frame_Tick = 1'b1;
      cyc();
      wait_load();
      repeat (6) cyc();
      chk("s5_respawn_x", int'(Rd_X), 150);

      // Frame tick during the capture cycle: new slot unscrolled, old slot scrolled.
      Gen_X = 10'd20;
      tick(SI);
      wait_load();
      repeat (3) cyc();
      Scroll_Speed = 4'd5;
      Frame_Tick = 1'b1;
      cyc();
      Scroll_Speed = 4'd0;
      chk("s6_old_scrolled", int'(Rd_X), 145);
      Rd_Slot = 2'd1;
      cyc();
      chk("s6_new_valid", int'(Rd_Valid), 1);
      chk("s6_new_unscrolled", int'(Rd_X), 160);
      repeat (3) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/barrier_spawn_scheduler.md
Name: barrier_spawn_scheduler

Overview:
- Owns a fixed pool of barrier slots and sequences the random barrier-parameter generator to fill them.
- Every SPAWN_INTERVAL frames it pulses the generator's load input, waits for the parameters to settle, then captures them into a free slot.
- On each frame tick it scrolls active slots left and frees any slot that leaves the screen.
- Sits between the frame timing logic, the parameter generator and the collision and draw logic; the latter two read slots through a registered read port.

Parameters:
- NUM_SLOTS, 4, number of barrier slots (power of two, 2..8).
- SPAWN_INTERVAL, 90, frame ticks between spawn attempts (1..255).
- GEN_LATENCY, 2, Clk cycles from the end of the Gen_Load pulse to valid Gen_* outputs (1..7).
- SPAWN_X_OFFSET, 140, added to Gen_X to form the on-screen start X.

Ports:
- Clk  in  1  system clock.
- Reset_N  in  1  asynchronous active-low reset.
- Enable  in  1  game running; when low, timers and scrolling freeze and slots hold.
- Clear  in  1  synchronous clear of all slots, FSM and timer.
- Frame_Tick  in  1  one-Clk pulse per video frame.
- Scroll_Speed  in  4  pixels per frame.
- Gen_Load  out  1  one-cycle load pulse to the generator.
- Gen_X, Gen_Y, Gen_Height, Gen_Length  in  10 each  generator outputs.
- Rd_Slot  in  $clog2(NUM_SLOTS)  slot index to read.
- Rd_Valid  out  1  selected slot is active.
- Rd_X, Rd_Y, Rd_Height, Rd_Length  out  10 each  selected slot's fields.
- Active_Count  out  4  number of active slots.
- Spawn_Pending  out  1  spawn is due but no slot is free.

Behaviour:
- Reset (Reset_N low, async):
  - All outputs 0, all slots invalid with fields 0.
  - FSM goes to IDLE; frame counter is 0; Spawn_Pending is 0.
- Clear: same effect as reset, taken on the next Clk edge. Clear has priority over every other event, including a spawn in progress. A Clear during WAIT means no capture occurs.
- Frame counter:
  - Increments on Frame_Tick when Enable is high.
  - When it reaches SPAWN_INTERVAL-1 on a tick, it wraps to 0 and sets the internal spawn_due flag.
- FSM states IDLE, LOAD, WAIT, CAPTURE:
  - IDLE -> LOAD when spawn_due and a free slot exists and Enable is high.
  - LOAD: Gen_Load=1 for exactly one cycle -> WAIT.
  - WAIT: counts GEN_LATENCY cycles -> CAPTURE.
  - CAPTURE: writes the lowest-index free slot, sets it valid, clears spawn_due -> IDLE.
  - Total latency from leaving IDLE to slot valid is GEN_LATENCY+2 cycles.
- Capture fields:
  - X = Gen_X + SPAWN_X_OFFSET, saturating at 1023.
  - Y, Height and Length are copied unchanged.
- Full pool: if spawn_due is set and all slots are valid, Spawn_Pending=1 and the FSM stays in IDLE.
  - The spawn proceeds on the first cycle a slot frees.
  - A further interval expiry while already due is absorbed, not queued.
- Scroll: on Frame_Tick with Enable high, each valid slot checks X against Scroll_Speed:
  - If X >= Scroll_Speed, X <= X - Scroll_Speed.
  - Otherwise (underflow) the slot goes invalid and its fields are zeroed.
  - A Scroll_Speed of 0 holds every slot.
- Simultaneous events:
  - A slot written in CAPTURE in the same cycle as Frame_Tick is not scrolled that cycle.
  - A slot freed by scroll in cycle N is eligible for capture from cycle N+1.
- Enable low during LOAD or WAIT: the FSM completes the capture, so the generator handshake is never abandoned.
- Read port: Rd_* are registered with a 1-cycle latency from Rd_Slot and reflect the slot state after that edge's updates.
- Active_Count: registered popcount of the valid bits, 1-cycle latency.

Decomposition:
- Shared package barrier_pkg holds:
  - typedef barrier_t (x, y, height, length, 10 bits each, plus a valid bit);
  - the enum typedef for the FSM states;
  - the constants SCREEN_W=640 and COORD_W=10.
- One sub-module, barrier_slot, holds one slot's register and its scroll/free/write logic. It is instantiated NUM_SLOTS times under a generate loop.

Test Plan:
- Reset, Enable=1, 90 Frame_Ticks, Gen_X=200, Gen_Y=45, Gen_Height=20, Gen_Length=30 -> exactly one Gen_Load pulse; 4 cycles after leaving IDLE, slot0 holds X=340, Y=45, H=20, L=30, valid; Active_Count=1.
- Slot X=10, Scroll_Speed=4 -> after ticks X reads 6, then 2; on the next tick the slot goes invalid and Rd_Valid=0.
- Fill all 4 slots, let the next interval expire -> Spawn_Pending=1 and no Gen_Load; after slot2 scrolls off, Gen_Load is pulsed on the following cycle and slot2 is refilled.
- Gen_X=1000 -> captured X saturates at 1023.
- Assert Clear during WAIT -> no capture occurs, all Rd_Valid=0, the frame counter restarts (next Gen_Load after 90 ticks).
- Frame_Tick in the CAPTURE cycle with Scroll_Speed=5 -> new slot X equals Gen_X+140 unscrolled, while existing slots drop by 5.
